video_chunk_fetcher: RTL and testbench

- Requester end of the video pipeline chunk protocol.
- On each line request it enqueues chunk requests {vPos, chunkNum} into the pipeline request FIFO.
- It drains the returned 16-bit RGB565 pixels from the pipeline response FIFO and writes them, in order, into a line buffer at their horizontal position.
- Sits downstream of a pipeline source (generator, scaler, framebuffer reader), driven by the display timing.

---
 rtl/video_chunk_fetcher.sv | 172 +++++++++++++++++
 tb/tb_video_chunk_fetcher.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_chunk_fetcher.sv
// rtl/video_chunk_fetcher.sv - requester end of the video pipeline chunk protocol
//
// Purpose: on each line request, issues chunk requests {vPos, chunkNum} into
// the pipeline request FIFO. Drains returned RGB565 pixels from the response
// FIFO and writes them, in order, into a line buffer at their hPos.
//
// Ports:
//   scalerClock            sole clock
//   resetN                 synchronous active-low reset
//   lineRequest            pulse: fetch line lineNum (chunksPerLine chunks)
//   lineNum[10:0]          vPos of line to fetch, sampled with lineRequest
//   chunksPerLine[6:0]     chunks in the line (0..64), sampled with lineRequest
//   busy                   line fetch in progress
//   lineDone               pulse: last pixel of line written
//   lineRequestDropped     pulse: lineRequest arrived while busy
//   requestFifoWriteEnable push request
//   requestFifoFull        request FIFO full
//   requestFifoWriteData   {vPos, chunkNum}
//   responseFifoReadEnable pop pixel
//   responseFifoEmpty      response FIFO empty
//   responseFifoReadData   pixel, valid the cycle after a pop
//   lineBufferWriteEnable  line buffer write strobe
//   lineBufferWriteAddress hPos of the pixel being written
//   lineBufferWriteData    pixel being written
module video_chunk_fetcher #(
  parameter int CHUNK_BITS      = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  scalerClock,
  input  logic                  resetN,
  input  logic                  lineRequest,
  input  logic [10:0]           lineNum,
  input  logic [6:0]            chunksPerLine,
  output logic                  busy,
  output logic                  lineDone,
  output logic                  lineRequestDropped,
  output logic                  requestFifoWriteEnable,
  input  logic                  requestFifoFull,
  output logic [21-CHUNK_BITS:0] requestFifoWriteData,
  output logic                  responseFifoReadEnable,
  input  logic                  responseFifoEmpty,
  input  logic [15:0]           responseFifoReadData,
  output logic                  lineBufferWriteEnable,
  output logic [10:0]           lineBufferWriteAddress,
  output logic [15:0]           lineBufferWriteData
);

  localparam int CHUNKNUM_BITS = 11 - CHUNK_BITS;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [10:0] line_q, line_d;
  logic [6:0]  chunks_q, chunks_d;
  logic [6:0]  issued_q, issued_d;
  logic [11:0] read_q, read_d;
  logic [3:0]  outst_q, outst_d;
  logic        busy_q, busy_d;
  logic        zero_done_q, zero_done_d;
  logic        dropped_q, dropped_d;
  logic        lb_we_q, lb_we_d;
  logic [10:0] lb_addr_q, lb_addr_d;

  logic [11:0] total_pixels;
  logic        pop_ends_chunk;
  logic        line_complete;
  logic [CHUNKNUM_BITS-1:0] chunk_num;

  // 12 bits so a 64-chunk line (2048 pixels) is representable without wrap.
  assign total_pixels = 12'(chunks_q) << CHUNK_BITS;
  assign chunk_num    = CHUNKNUM_BITS'(issued_q);

  assign requestFifoWriteEnable = (state_q == FETCH) && !requestFifoFull &&
                                  (issued_q < chunks_q) &&
                                  (outst_q < 4'(MAX_OUTSTANDING));
  assign requestFifoWriteData   = {line_q, chunk_num};

  assign responseFifoReadEnable = (state_q == FETCH) && !responseFifoEmpty &&
                                  (read_q < total_pixels);

  // The pop that consumes the last pixel of a chunk frees one outstanding slot.
  assign pop_ends_chunk = responseFifoReadEnable && (&read_q[CHUNK_BITS-1:0]);

  // Completion is flagged in the same cycle as the final line buffer write.
  assign line_complete = (state_q == FETCH) && lb_we_q &&
                         ({1'b0, lb_addr_q} == (total_pixels - 12'd1));

  assign busy                   = busy_q;
  assign lineDone               = zero_done_q | line_complete;
  assign lineRequestDropped     = dropped_q;
  assign lineBufferWriteEnable  = lb_we_q;
  assign lineBufferWriteAddress = lb_addr_q;
  assign lineBufferWriteData    = responseFifoReadData;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    chunks_d    = chunks_q;
    issued_d    = issued_q;
    read_d      = read_q;
    outst_d     = outst_q;
    busy_d      = busy_q;
    zero_done_d = 1'b0;
    dropped_d   = 1'b0;
    lb_we_d     = responseFifoReadEnable;
    lb_addr_d   = responseFifoReadEnable ? read_q[10:0] : lb_addr_q;

    case (state_q)
      IDLE: begin
        if (lineRequest) begin
          line_d   = lineNum;
          chunks_d = chunksPerLine;
          issued_d = 7'd0;
          read_d   = 12'd0;
          outst_d  = 4'd0;
          if (chunksPerLine == 7'd0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = FETCH;
            busy_d  = 1'b1;
          end
        end
      end
      FETCH: begin
        if (requestFifoWriteEnable) issued_d = issued_q + 7'd1;
        if (responseFifoReadEnable) read_d = read_q + 12'd1;
        case ({requestFifoWriteEnable, pop_ends_chunk})
          2'b10:   outst_d = outst_q + 4'd1;
          2'b01:   outst_d = outst_q - 4'd1;
          default: outst_d = outst_q;
        endcase
        // Requests during a fetch (including the lineDone cycle) are refused.
        if (lineRequest) dropped_d = 1'b1;
        if (line_complete) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge scalerClock) begin
    if (!resetN) begin
      state_q     <= IDLE;
      line_q      <= 11'd0;
      chunks_q    <= 7'd0;
      issued_q    <= 7'd0;
      read_q      <= 12'd0;
      outst_q     <= 4'd0;
      busy_q      <= 1'b0;
      zero_done_q <= 1'b0;
      dropped_q   <= 1'b0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= 11'd0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      chunks_q    <= chunks_d;
      issued_q    <= issued_d;
      read_q      <= read_d;
      outst_q     <= outst_d;
      busy_q      <= busy_d;
      zero_done_q <= zero_done_d;
      dropped_q   <= dropped_d;
      lb_we_q     <= lb_we_d;
      lb_addr_q   <= lb_addr_d;
    end
  end

endmodule

// File: tb/tb_video_chunk_fetcher.sv
// tb/tb_video_chunk_fetcher.sv - directed self-checking bench for video_chunk_fetcher
module tb_video_chunk_fetcher;

  logic        scalerClock = 1'b0;
  logic        resetN;
  logic        lineRequest;
  logic [10:0] lineNum;
  logic [6:0]  chunksPerLine;
  logic        busy, lineDone, lineRequestDropped;
  logic        requestFifoWriteEnable, requestFifoFull;
  logic [16:0] requestFifoWriteData;
  logic        responseFifoReadEnable, responseFifoEmpty;
  logic [15:0] responseFifoReadData;
  logic        lineBufferWriteEnable;
  logic [10:0] lineBufferWriteAddress;
  logic [15:0] lineBufferWriteData;

  always #5 scalerClock = ~scalerClock;

  video_chunk_fetcher #(.CHUNK_BITS(5), .MAX_OUTSTANDING(4)) dut (
    .scalerClock            (scalerClock),
    .resetN                 (resetN),
    .lineRequest            (lineRequest),
    .lineNum                (lineNum),
    .chunksPerLine          (chunksPerLine),
    .busy                   (busy),
    .lineDone               (lineDone),
    .lineRequestDropped     (lineRequestDropped),
    .requestFifoWriteEnable (requestFifoWriteEnable),
    .requestFifoFull        (requestFifoFull),
    .requestFifoWriteData   (requestFifoWriteData),
    .responseFifoReadEnable (responseFifoReadEnable),
    .responseFifoEmpty      (responseFifoEmpty),
    .responseFifoReadData   (responseFifoReadData),
    .lineBufferWriteEnable  (lineBufferWriteEnable),
    .lineBufferWriteAddress (lineBufferWriteAddress),
    .lineBufferWriteData    (lineBufferWriteData)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge scalerClock) cyc <= cyc + 1;

  function automatic logic [15:0] pix(int g);
    return 16'hC000 ^ 16'(g * 7);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response FIFO model: 'avail' pixels have been delivered so far.
  int avail = 0;
  int popped = 0;
  logic [15:0] rdata = 16'h0;
  assign responseFifoEmpty    = (avail <= popped);
  assign responseFifoReadData = rdata;

  always @(posedge scalerClock) begin
    if (!resetN) popped <= 0;
    else if (responseFifoReadEnable) begin
      rdata  <= pix(popped);
      popped <= popped + 1;
    end
  end

  // Monitor: logs requests, checks every line buffer write and protocol gating.
  logic [16:0] req_data[$];
  int          req_cyc[$];
  int          exp_addr = 0;
  int          wr_total = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_we = 1'b0;
  logic [10:0] done_addr = 11'd0;
  int          drop_cnt = 0;
  int          drop_cyc = 0;

  always @(negedge scalerClock) begin
    if (!resetN) begin
      exp_addr <= 0;
      wr_total <= 0;
    end else begin
      if (requestFifoWriteEnable) begin
        check("req_while_full", requestFifoFull, 0);
        req_data.push_back(requestFifoWriteData);
        req_cyc.push_back(cyc);
      end
      if (responseFifoReadEnable) check("pop_while_empty", responseFifoEmpty, 0);
      if (lineBufferWriteEnable) begin
        check("lb_addr", lineBufferWriteAddress, exp_addr);
        check("lb_data", lineBufferWriteData, pix(wr_total));
        exp_addr <= exp_addr + 1;
        wr_total <= wr_total + 1;
      end
      if (lineDone) begin
        done_cnt  <= done_cnt + 1;
        done_cyc  <= cyc;
        done_we   <= lineBufferWriteEnable;
        done_addr <= lineBufferWriteAddress;
        exp_addr  <= 0;
      end
      if (lineRequestDropped) begin
        drop_cnt <= drop_cnt + 1;
        drop_cyc <= cyc;
      end
    end
  end

  task automatic step();
    @(posedge scalerClock);
    #1;
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  task automatic request(logic [10:0] ln, logic [6:0] cn, output int s);
    lineNum       = ln;
    chunksPerLine = cn;
    lineRequest   = 1'b1;
    s             = cyc;
    step();
    lineRequest   = 1'b0;
  endtask

  task automatic wait_done(int base, int budget, string tag);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      step();
      k++;
    end
    check(tag, done_cnt, base + 1);
  endtask

  initial begin
    int s, t, r0, d0, w0, p0;
    resetN          = 1'b0;
    lineRequest     = 1'b0;
    lineNum         = 11'd0;
    chunksPerLine   = 7'd0;
    requestFifoFull = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", lineDone, 0);
    check("rst_drop", lineRequestDropped, 0);
    check("rst_lbwe", lineBufferWriteEnable, 0);
    check("rst_lbaddr", lineBufferWriteAddress, 0);
    check("rst_wen", requestFifoWriteEnable, 0);
    check("rst_ren", responseFifoReadEnable, 0);
    resetN = 1'b1;
    step();

    // Line 5, two chunks, responses always available.
    r0 = req_data.size(); d0 = done_cnt; w0 = wr_total;
    avail += 64;
    request(11'd5, 7'd2, s);
    check("t1_busy", busy, 1);
    wait_done(d0, 200, "t1_done_timeout");
    check("t1_done_cyc", done_cyc, s + 65);
    check("t1_done_we", done_we, 1);
    check("t1_done_addr", done_addr, 63);
    check("t1_busy_drop", busy, 0);
    check("t1_nreq", req_data.size(), r0 + 2);
    check("t1_req0", req_data[r0], 17'h00140);
    check("t1_req1", req_data[r0+1], 17'h00141);
    check("t1_req0_cyc", req_cyc[r0], s + 1);
    check("t1_req1_cyc", req_cyc[r0+1], s + 2);
    check("t1_writes", wr_total, w0 + 64);

    // Request FIFO full for the first 10 cycles after the request.
    r0 = req_data.size(); d0 = done_cnt;
    requestFifoFull = 1'b1;
    request(11'd9, 7'd3, s);
    run_to(s + 10);
    check("t2_no_req_full", req_data.size(), r0);
    run_to(s + 11);
    requestFifoFull = 1'b0;
    avail += 96;
    wait_done(d0, 300, "t2_done_timeout");
    check("t2_nreq", req_data.size(), r0 + 3);
    check("t2_req0", req_data[r0], 17'h00240);
    check("t2_req2", req_data[r0+2], 17'h00242);
    check("t2_req0_cyc", req_cyc[r0], s + 11);
    check("t2_req2_cyc", req_cyc[r0+2], s + 13);
    check("t2_done_cyc", done_cyc, s + 107);
    check("t2_done_addr", done_addr, 95);

    // Outstanding limit: empty response FIFO stalls after 4 requests.
    r0 = req_data.size(); d0 = done_cnt; w0 = wr_total;
    request(11'd3, 7'd8, s);
    run_to(s + 10);
    check("t3_stall_nreq", req_data.size(), r0 + 4);
    check("t3_req3_cyc", req_cyc[r0+3], s + 4);
    t = cyc;
    avail += 32;
    run_to(t + 34);
    check("t3_fifth_nreq", req_data.size(), r0 + 5);
    check("t3_fifth_cyc", req_cyc[r0+4], t + 32);
    check("t3_fifth_data", req_data[r0+4], 17'h000C4);
    avail += 224;
    wait_done(d0, 600, "t3_done_timeout");
    check("t3_nreq", req_data.size(), r0 + 8);
    check("t3_last_req", req_data[r0+7], 17'h000C7);
    check("t3_done_addr", done_addr, 255);
    check("t3_writes", wr_total, w0 + 256);

    // Zero-chunk line.
    r0 = req_data.size(); d0 = done_cnt; p0 = popped;
    request(11'd100, 7'd0, s);
    check("t4_done_pulse", lineDone, 1);
    check("t4_busy", busy, 0);
    step();
    check("t4_done_low", lineDone, 0);
    check("t4_nreq", req_data.size(), r0);
    check("t4_npop", popped, p0);
    check("t4_done_cnt", done_cnt, d0 + 1);

    // Requests while busy are dropped; request right after lineDone accepted.
    r0 = req_data.size(); d0 = drop_cnt; w0 = wr_total;
    avail += 64;
    request(11'd7, 7'd2, s);
    run_to(s + 5);
    lineNum = 11'd12; chunksPerLine = 7'd1; lineRequest = 1'b1;
    step();
    lineRequest = 1'b0;
    run_to(s + 65);
    check("t5_done_pulse", lineDone, 1);
    lineNum = 11'd20; chunksPerLine = 7'd5; lineRequest = 1'b1;
    step();
    lineNum = 11'd2; chunksPerLine = 7'd1;
    avail += 32;
    step();
    lineRequest = 1'b0;
    check("t5_busy_new", busy, 1);
    check("t5_drop_cnt", drop_cnt, d0 + 2);
    check("t5_drop_cyc", drop_cyc, s + 66);
    check("t5_req0", req_data[r0], 17'h001C0);
    check("t5_req1", req_data[r0+1], 17'h001C1);
    check("t5_writes", wr_total, w0 + 64);
    d0 = done_cnt;
    wait_done(d0, 100, "t5_done_timeout");
    check("t5_req_new", req_data[r0+2], 17'h00080);
    check("t5_nreq", req_data.size(), r0 + 3);
    check("t5_done_addr", done_addr, 31);

    // Reset in the middle of a line.
    d0 = done_cnt; w0 = wr_total;
    avail += 40;
    request(11'd10, 7'd4, s);
    run_to(s + 45);
    check("t6_partial", wr_total, w0 + 40);
    resetN = 1'b0;
    avail  = 0;
    step();
    resetN = 1'b1;
    check("t6_busy", busy, 0);
    check("t6_done", lineDone, 0);
    check("t6_drop", lineRequestDropped, 0);
    check("t6_lbwe", lineBufferWriteEnable, 0);
    check("t6_lbaddr", lineBufferWriteAddress, 0);
    check("t6_wen", requestFifoWriteEnable, 0);
    check("t6_ren", responseFifoReadEnable, 0);
    check("t6_no_done", done_cnt, d0);
    r0 = req_data.size();
    avail = 32;
    request(11'd11, 7'd1, s);
    wait_done(d0, 100, "t6_done_timeout");
    check("t6_req0", req_data[r0], 17'h002C0);
    check("t6_done_addr", done_addr, 31);
    check("t6_writes", wr_total, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
